// File: rtl/icache_fifo.sv
// Read-only set-associative instruction cache with per-set FIFO replacement.
// Misses refill a whole block, one word per valid memory beat, then lookups resume.
module icache_fifo #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int WORD_SIZE         = 4,
  parameter int BLOCK_SIZE        = 1,
  parameter int DEG_ASSOCIATIVITY = 1,
  parameter int CAPACITY          = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  hit,
  output logic                  miss,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_instr,
  input  logic                  mem_instr_valid,
  output logic                  mem_req
);

  localparam int NUM_SETS = CAPACITY / (BLOCK_SIZE * DEG_ASSOCIATIVITY);
  localparam int OFF_W    = $clog2(WORD_SIZE);
  localparam int WIB_W    = $clog2(BLOCK_SIZE);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int WAY_W    = $clog2(DEG_ASSOCIATIVITY);
  localparam int TAG_W    = ADDR_WIDTH - OFF_W - WIB_W - IDX_W;
  // Zero-width fields still get one storage bit; their value is always 0.
  localparam int WIB_S    = (WIB_W > 0) ? WIB_W : 1;
  localparam int IDX_S    = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_S    = (WAY_W > 0) ? WAY_W : 1;
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(BLOCK_SIZE * WORD_SIZE - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_q, state_d;

  logic                  valid_arr [NUM_SETS][DEG_ASSOCIATIVITY];
  logic [TAG_W-1:0]      tag_arr   [NUM_SETS][DEG_ASSOCIATIVITY];
  logic [DATA_WIDTH-1:0] data_arr  [NUM_SETS][DEG_ASSOCIATIVITY][BLOCK_SIZE];
  logic [WAY_S-1:0]      fifo_ptr  [NUM_SETS];

  logic [IDX_S-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WIB_S-1:0]      word_off;
  logic                  lookup_hit;
  logic [WAY_S-1:0]      hit_way;
  logic [DATA_WIDTH-1:0] hit_word;

  logic [WIB_S-1:0]      beat;
  logic [WIB_S-1:0]      req_word;
  logic [TAG_W-1:0]      lat_tag;
  logic [IDX_S-1:0]      lat_idx;
  logic [WAY_S-1:0]      victim;
  logic                  accept;
  logic                  last_beat;

  assign idx      = IDX_S'((instr_addr >> (OFF_W + WIB_W)) & ADDR_WIDTH'(NUM_SETS - 1));
  assign tag      = TAG_W'(instr_addr >> (OFF_W + WIB_W + IDX_W));
  assign word_off = WIB_S'((instr_addr >> OFF_W) & ADDR_WIDTH'(BLOCK_SIZE - 1));
  assign hit_word = data_arr[idx][hit_way][word_off];

  assign victim    = fifo_ptr[lat_idx];
  assign accept    = (state_q == REFILL) && mem_instr_valid;
  assign last_beat = (beat == WIB_S'(BLOCK_SIZE - 1));

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < DEG_ASSOCIATIVITY; w++) begin
      if (valid_arr[idx][w] && (tag_arr[idx][w] == tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_S'(w);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!lookup_hit) state_d = REFILL;
      REFILL:  if (accept && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tags and data are only ever read behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_arr[lat_idx][victim][beat] <= mem_instr;
      if (last_beat) tag_arr[lat_idx][victim] <= lat_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      instr    <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      beat     <= '0;
      req_word <= '0;
      lat_tag  <= '0;
      lat_idx  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        fifo_ptr[s] <= '0;
        for (int w = 0; w < DEG_ASSOCIATIVITY; w++) valid_arr[s][w] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      hit     <= 1'b0;
      miss    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lookup_hit) begin
            hit   <= 1'b1;
            instr <= hit_word;
          end else begin
            miss     <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= instr_addr & ~BLK_MASK;
            lat_tag  <= tag;
            lat_idx  <= idx;
            req_word <= word_off;
            beat     <= '0;
          end
        end
        REFILL: begin
          if (mem_instr_valid) begin
            if (beat == req_word) instr <= mem_instr;
            if (last_beat) begin
              valid_arr[lat_idx][victim] <= 1'b1;
              fifo_ptr[lat_idx] <= (victim == WAY_S'(DEG_ASSOCIATIVITY - 1)) ? '0 : victim + 1'b1;
              mem_req <= 1'b0;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= mem_addr + ADDR_WIDTH'(WORD_SIZE);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fifo.sv
// Directed bench for icache_fifo: three instances cover direct-mapped,
// 2-way FIFO replacement and 4-word blocks, sharing clock, reset and inputs.
module tb_icache_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_addr = '0;
  logic [31:0] mem_instr = '0;
  logic        mem_instr_valid = 1'b0;

  logic [31:0] instr0, maddr0, instr1, maddr1, instr2, maddr2;
  logic        hit0, miss0, mreq0, hit1, miss1, mreq1, hit2, miss2, mreq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_fifo u_dm (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr0), .hit(hit0),
    .miss(miss0), .mem_addr(maddr0), .mem_instr(mem_instr),
    .mem_instr_valid(mem_instr_valid), .mem_req(mreq0)
  );

  icache_fifo #(.DEG_ASSOCIATIVITY(2)) u_2way (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr1), .hit(hit1),
    .miss(miss1), .mem_addr(maddr1), .mem_instr(mem_instr),
    .mem_instr_valid(mem_instr_valid), .mem_req(mreq1)
  );

  icache_fifo #(.BLOCK_SIZE(4)) u_blk4 (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr2), .hit(hit2),
    .miss(miss2), .mem_addr(maddr2), .mem_instr(mem_instr),
    .mem_instr_valid(mem_instr_valid), .mem_req(mreq2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] data);
    mem_instr       = data;
    mem_instr_valid = 1'b1;
    step();
    mem_instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_instr_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // flags are packed as {hit, miss, mem_req}
  task automatic sample(input int sel, output logic [2:0] f, output logic [31:0] a,
                        output logic [31:0] d);
    case (sel)
      0:       begin f = {hit0, miss0, mreq0}; a = maddr0; d = instr0; end
      1:       begin f = {hit1, miss1, mreq1}; a = maddr1; d = instr1; end
      default: begin f = {hit2, miss2, mreq2}; a = maddr2; d = instr2; end
    endcase
  endtask

  task automatic test_reset();
    logic [2:0] f;
    logic [31:0] a, d;
    step();
    for (int s = 0; s < 3; s++) begin
      sample(s, f, a, d);
      checks++;
      if (f !== 3'b000 || a !== 32'h0 || d !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got flags=%b addr=%h instr=%h want 000/0/0", s, f, a, d);
      end
    end
  endtask

  task automatic test_basic();
    logic [2:0] f;
    logic [31:0] a, d;
    do_reset();
    instr_addr = 32'h0;
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h0) begin
      errors++; $display("[TB] FAIL basic_miss: got flags=%b addr=%h want 011/0", f, a);
    end
    feed(32'h1000_0000);
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b000 || d !== 32'h1000_0000) begin
      errors++; $display("[TB] FAIL basic_refill: got flags=%b instr=%h want 000/10000000", f, d);
    end
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b100 || d !== 32'h1000_0000) begin
      errors++; $display("[TB] FAIL basic_hit: got flags=%b instr=%h want 100/10000000", f, d);
    end
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b100) begin
      errors++; $display("[TB] FAIL back_to_back_hit: got flags=%b want 100", f);
    end
  endtask

  task automatic test_evict_1way();
    logic [2:0] f;
    logic [31:0] a, d;
    instr_addr = 32'h400;
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h400 || d !== 32'h1000_0000) begin
      errors++; $display("[TB] FAIL evict_miss_400: got flags=%b addr=%h instr=%h want 011/400/10000000", f, a, d);
    end
    feed(32'h1000_0100);
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b000 || d !== 32'h1000_0100) begin
      errors++; $display("[TB] FAIL evict_refill_400: got flags=%b instr=%h want 000/10000100", f, d);
    end
    instr_addr = 32'h0;
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h0) begin
      errors++; $display("[TB] FAIL evict_miss_0: got flags=%b addr=%h want 011/0", f, a);
    end
    feed(32'h1000_0000);
  endtask

  task automatic test_fifo_2way();
    logic [2:0] f;
    logic [31:0] a, d;
    do_reset();
    instr_addr = 32'h0;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b011) begin errors++; $display("[TB] FAIL fifo_miss_a: got flags=%b want 011", f); end
    feed(32'h1000_0000);
    instr_addr = 32'h200;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h200) begin
      errors++; $display("[TB] FAIL fifo_miss_b: got flags=%b addr=%h want 011/200", f, a);
    end
    feed(32'h1000_0080);
    instr_addr = 32'h0;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b100 || d !== 32'h1000_0000) begin
      errors++; $display("[TB] FAIL fifo_hit_a: got flags=%b instr=%h want 100/10000000", f, d);
    end
    instr_addr = 32'h400;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b011) begin errors++; $display("[TB] FAIL fifo_miss_c: got flags=%b want 011", f); end
    feed(32'h1000_0100);
    instr_addr = 32'h200;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b100 || d !== 32'h1000_0080) begin
      errors++; $display("[TB] FAIL fifo_hit_b: got flags=%b instr=%h want 100/10000080", f, d);
    end
    instr_addr = 32'h0;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b011) begin errors++; $display("[TB] FAIL fifo_a_evicted: got flags=%b want 011", f); end
    feed(32'h1000_0000);
    instr_addr = 32'h400;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b100 || d !== 32'h1000_0100) begin
      errors++; $display("[TB] FAIL fifo_hit_c: got flags=%b instr=%h want 100/10000100", f, d);
    end
    instr_addr = 32'h200;
    step();
    sample(1, f, a, d);
    checks++;
    if (f !== 3'b011) begin errors++; $display("[TB] FAIL fifo_wrap_b_evicted: got flags=%b want 011", f); end
    feed(32'h1000_0080);
  endtask

  task automatic test_block4();
    logic [2:0] f;
    logic [31:0] a, d;
    do_reset();
    instr_addr = 32'h8;
    step();
    sample(2, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h0) begin
      errors++; $display("[TB] FAIL blk_miss: got flags=%b addr=%h want 011/0", f, a);
    end
    for (int i = 0; i < 4; i++) begin
      feed(32'h1000_0000 + 32'(i));
      sample(2, f, a, d);
      checks++;
      if (i < 3 && (f !== 3'b001 || a !== 32'(4 * (i + 1)))) begin
        errors++; $display("[TB] FAIL blk_beat%0d: got flags=%b addr=%h want 001/%h", i, f, a, 4 * (i + 1));
      end else if (i == 3 && (f !== 3'b000 || d !== 32'h1000_0002)) begin
        errors++; $display("[TB] FAIL blk_last: got flags=%b instr=%h want 000/10000002", f, d);
      end
      if (i == 1) begin
        step();
        sample(2, f, a, d);
        checks++;
        if (f !== 3'b001 || a !== 32'h8) begin
          errors++; $display("[TB] FAIL blk_stall: got flags=%b addr=%h want 001/8", f, a);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) continue;
      instr_addr = 32'(4 * i);
      step();
      sample(2, f, a, d);
      checks++;
      if (f !== 3'b100 || d !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("[TB] FAIL blk_hit_word%0d: got flags=%b instr=%h want 100/%h", i, f, d, 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [2:0] f;
    logic [31:0] a, d;
    do_reset();
    instr_addr = 32'h40;
    step();
    feed(32'h1000_0010);
    instr_addr = 32'h440;
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h440 || d !== 32'h1000_0010) begin
      errors++; $display("[TB] FAIL midrst_setup: got flags=%b addr=%h instr=%h want 011/440/10000010", f, a, d);
    end
    #2 rst = 1'b1;
    #1;
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b000 || a !== 32'h0 || d !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_async: got flags=%b addr=%h instr=%h want 000/0/0", f, a, d);
    end
    step();
    rst = 1'b0;
    instr_addr = 32'h40;
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h40) begin
      errors++; $display("[TB] FAIL midrst_remiss: got flags=%b addr=%h want 011/40", f, a);
    end
    feed(32'h1000_0010);
  endtask

  task automatic test_idle_valid();
    logic [2:0] f;
    logic [31:0] a, d;
    instr_addr      = 32'h40;
    mem_instr       = 32'hDEAD_BEEF;
    mem_instr_valid = 1'b1;
    step();
    step();
    mem_instr_valid = 1'b0;
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b100 || d !== 32'h1000_0010) begin
      errors++; $display("[TB] FAIL idle_valid_hit: got flags=%b instr=%h want 100/10000010", f, d);
    end
    instr_addr = 32'h80;
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b011 || a !== 32'h80) begin
      errors++; $display("[TB] FAIL idle_valid_noline: got flags=%b addr=%h want 011/80", f, a);
    end
    feed(32'h1000_0020);
    step();
    sample(0, f, a, d);
    checks++;
    if (f !== 3'b100 || d !== 32'h1000_0020) begin
      errors++; $display("[TB] FAIL idle_valid_refhit: got flags=%b instr=%h want 100/10000020", f, d);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time=%0t want finish before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_evict_1way();
    test_fifo_2way();
    test_block4();
    test_reset_mid_refill();
    test_idle_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
